// File: rtl/fp16_pkg.sv
// Shared FP16 constants, types and helpers for the accumulator slice.
package fp16_pkg;
  localparam int          EXP_BITS   = 5;
  localparam int          MAN_BITS   = 10;
  localparam int          BIAS       = 15;
  localparam logic [15:0] FP16_MAX   = 16'h7BFF;
  localparam int          GUARD_BITS = 3;
  localparam int          SIG_W      = 1 + MAN_BITS + GUARD_BITS;

  typedef struct packed {
    logic                sign;
    logic [EXP_BITS-1:0] exp;
    logic [MAN_BITS-1:0] man;
  } fp16_t;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } acc_state_t;

  // Leading-zero count of the raw significand (one carry bit above SIG_W).
  function automatic logic [3:0] lzc15(input logic [SIG_W:0] v);
    lzc15 = 4'd15;
    for (int i = 0; i <= SIG_W; i++) begin
      if (v[i]) lzc15 = 4'(SIG_W - i);
    end
  endfunction
endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder: flush-to-zero, truncating, no sticky bit.
// Saturation on exponent overflow when FP16_ACC_SAT_EN is defined, otherwise the exponent wraps.
module fp16_add
  import fp16_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output fp16_t sum,
  output logic  ovf
);

  fp16_t               big;
  fp16_t               sml;
  logic [EXP_BITS-1:0] diff;
  logic [SIG_W-1:0]    sig_big;
  logic [SIG_W-1:0]    sig_sml;
  logic [SIG_W:0]      raw;
  logic [SIG_W:0]      norm;
  logic [3:0]          lz;
  logic signed [6:0]   exp_n;

  always_comb begin
    sum = '0;
    ovf = 1'b0;
    if ({a.exp, a.man} >= {b.exp, b.man}) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    diff    = big.exp - sml.exp;
    sig_big = {1'b1, big.man, {GUARD_BITS{1'b0}}};
    sig_sml = (diff >= 5'(SIG_W)) ? '0 : ({1'b1, sml.man, {GUARD_BITS{1'b0}}} >> diff);
    raw     = (big.sign == sml.sign) ? ({1'b0, sig_big} + {1'b0, sig_sml})
                                     : ({1'b0, sig_big} - {1'b0, sig_sml});
    lz      = lzc15(raw);
    norm    = raw << lz;
    // The hidden bit of an aligned operand sits one below the carry bit.
    exp_n   = $signed({2'b00, big.exp}) + 7'sd1 - $signed({3'b000, lz});

    if (a.exp == '0 && b.exp == '0) begin
      sum = '0;
    end else if (a.exp == '0) begin
      sum = b;
    end else if (b.exp == '0) begin
      sum = a;
    end else if (raw == '0) begin
      sum = '0;
    end else if (exp_n < 7'sd1) begin
      sum = '0;
`ifdef FP16_ACC_SAT_EN
    end else if (exp_n >= 7'sd31) begin
      sum = {big.sign, FP16_MAX[14:0]};
      ovf = 1'b1;
`endif
    end else begin
      sum = {big.sign, exp_n[EXP_BITS-1:0], norm[SIG_W-1 -: MAN_BITS]};
    end
  end

endmodule

// File: rtl/fp16_acc.sv
// FP16 accumulator: sums handshaked product beats, one registered result per last beat.
// Optional saturation and sticky overflow flag enabled by FP16_ACC_SAT_EN.
module fp16_acc
  import fp16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [15:0]      product_i,
  input  logic             last_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [15:0]      sum_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);
  // state  | meaning
  // ST_ACC | accepting beats into the running sum
  // ST_OUT | holding the finished sum until downstream takes it

  acc_state_t       state;
  fp16_t            acc;
  fp16_t            add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] count;
  logic             ovf_q;

  fp16_add u_add (
    .a   (acc),
    .b   (fp16_t'(product_i)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_ACC;
      acc     <= '0;
      count   <= '0;
      ovf_q   <= 1'b0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (valid_i && ready_o) begin
            acc   <= add_sum;
            ovf_q <= ovf_q | add_ovf;
            if (count != '1) count <= count + CNT_W'(1);
            if (last_i) begin
              state   <= ST_OUT;
              ready_o <= 1'b0;
              valid_o <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (valid_o && ready_i) begin
            state   <= ST_ACC;
            acc     <= '0;
            count   <= '0;
            ovf_q   <= 1'b0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

  assign sum_o   = acc;
  assign count_o = count;
`ifdef FP16_ACC_SAT_EN
  assign ovf_o   = ovf_q;
`else
  assign ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fp16_acc.sv
// Scoreboard bench for fp16_acc: randomized packets against an arithmetic FP16 reference model.
module tb_fp16_acc;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             valid_i = 1'b0;
  logic             last_i = 1'b0;
  logic             ready_i = 1'b0;
  logic [15:0]      product_i = 16'h0;
  logic             ready_o, valid_o, ovf_o;
  logic [15:0]      sum_o;
  logic [CNT_W-1:0] count_o;

  fp16_acc #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .product_i(product_i), .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i),
    .sum_o(sum_o), .count_o(count_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] sum;
    int          count;
    logic        ovf;
  } res_t;

  res_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] m_acc = 16'h0;
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  int          rdy_mode = 0;
  logic        ov_en = 1'b0;
  logic [15:0] ov_sum;
  int          ov_cnt;
  logic        ov_ovf;

`ifdef FP16_ACC_SAT_EN
  localparam logic [15:0] BIG_SUM = 16'h7BFF;
  localparam logic        BIG_OVF = 1'b1;
`else
  localparam logic [15:0] BIG_SUM = 16'h7FFF;
  localparam logic        BIG_OVF = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Reference add on real magnitudes: integer significands scaled by 8, renormalized by halving/doubling.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, sb, ss, tot, e, diff;
    logic [15:0] big, sml;
    ea = a[14:10];
    eb = b[14:10];
    if (ea == 0 && eb == 0) return 17'h0;
    if (ea == 0) return {1'b0, b};
    if (eb == 0) return {1'b0, a};
    if (a[14:0] >= b[14:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    diff = int'(big[14:10]) - int'(sml[14:10]);
    sb = (1024 + int'(big[9:0])) * 8;
    ss = ((1024 + int'(sml[9:0])) * 8) >> diff;
    tot = (big[15] == sml[15]) ? sb + ss : sb - ss;
    if (tot == 0) return 17'h0;
    e = big[14:10];
    while (tot >= 16384) begin tot = tot / 2; e++; end
    while (tot < 8192) begin tot = tot * 2; e--; end
    if (e < 1) return 17'h0;
`ifdef FP16_ACC_SAT_EN
    if (e >= 31) return {1'b1, big[15], 15'h7BFF};
`endif
    return {1'b0, big[15], 5'(e), 10'(tot / 8 - 1024)};
  endfunction

  task automatic model_accept(input logic [15:0] p, input logic l);
    logic [16:0] r;
    res_t res;
    r = ref_add(m_acc, p);
    m_acc = r[15:0];
    m_ovf = m_ovf | r[16];
    if (m_cnt < CNT_MAX) m_cnt++;
    if (l) begin
      if (ov_en) begin
        res.sum = ov_sum; res.count = ov_cnt; res.ovf = ov_ovf;
      end else begin
        res.sum = m_acc; res.count = m_cnt; res.ovf = m_ovf;
      end
      exp_q.push_back(res);
      ov_en = 1'b0;
      m_acc = 16'h0; m_cnt = 0; m_ovf = 1'b0;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic send_beat(input logic [15:0] p, input logic l);
    logic done;
    done = 1'b0;
    valid_i = 1'b1; product_i = p; last_i = l;
    for (int n = 0; n < 300 && !done; n++) begin
      if (ready_o) begin
        model_accept(p, l);
        done = 1'b1;
      end
      @(negedge clk_i);
    end
    valid_i = 1'b0; last_i = 1'b0;
    check("beat accepted", done, 1);
    if (done && l) begin
      check("valid_o one cycle after last", valid_o, 1);
      check("ready_o low in OUT", ready_o, 0);
    end
  endtask

  task automatic expect_next(input logic [15:0] s, input int c, input logic o);
    ov_en = 1'b1; ov_sum = s; ov_cnt = c; ov_ovf = o;
  endtask

  task automatic check_reset_outputs();
    check("reset ready_o", ready_o, 1);
    check("reset valid_o", valid_o, 0);
    check("reset sum_o", sum_o, 0);
    check("reset count_o", count_o, 0);
    check("reset ovf_o", ovf_o, 0);
  endtask

  task automatic pulse_reset();
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_acc = 16'h0; m_cnt = 0; m_ovf = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk_i);
    check("scoreboard drained", exp_q.size(), 0);
  endtask

  function automatic logic [15:0] rand_fp16();
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
  endfunction

  // Monitor: drives ready_i, pops the scoreboard on each output handshake, checks hold stability.
  initial begin
    logic        held;
    logic [15:0] p_sum;
    logic [CNT_W-1:0] p_cnt;
    logic        p_ovf;
    res_t        r;
    held = 1'b0;
    forever begin
      @(negedge clk_i);
      case (rdy_mode)
        0: ready_i = ($urandom_range(0, 3) != 0);
        1: ready_i = 1'b0;
        default: ready_i = 1'b1;
      endcase
      if (rst_ni && valid_o) begin
        if (held) begin
          check("hold sum_o", sum_o, p_sum);
          check("hold count_o", count_o, p_cnt);
          check("hold ovf_o", ovf_o, p_ovf);
        end
        if (ready_i) begin
          held = 1'b0;
          check("result expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            check("sum_o", sum_o, r.sum);
            check("count_o", count_o, r.count);
            check("ovf_o", ovf_o, r.ovf);
          end
        end else begin
          held = 1'b1;
          p_sum = sum_o; p_cnt = count_o; p_ovf = ovf_o;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int len;
    #12 check_reset_outputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed packets with literal expectations
    expect_next(16'h4000, 2, 1'b0);
    send_beat(16'h3C00, 0); send_beat(16'h3C00, 1);
    expect_next(16'h3E00, 2, 1'b0);
    send_beat(16'h4000, 0); send_beat(16'hB800, 1);
    expect_next(16'h0000, 2, 1'b0);
    send_beat(16'h3C00, 0); send_beat(16'hBC00, 1);
    expect_next(16'h0000, 1, 1'b0);
    send_beat(16'h0001, 1);
    expect_next(BIG_SUM, 2, BIG_OVF);
    send_beat(16'h7BFF, 0); send_beat(16'h7BFF, 1);
    wait_drain();

    // Back-pressure: hold ready_i low for five cycles in OUT
    rdy_mode = 1;
    expect_next(16'h4000, 2, 1'b0);
    send_beat(16'h3C00, 0); send_beat(16'h3C00, 1);
    repeat (5) begin
      @(negedge clk_i);
      check("ready_o low while held", ready_o, 0);
      check("valid_o high while held", valid_o, 1);
    end
    rdy_mode = 2;
    wait_drain();
    expect_next(16'h4000, 1, 1'b0);
    send_beat(16'h4000, 1);
    wait_drain();
    rdy_mode = 0;

    // Reset mid-sum after three beats
    send_beat(16'h3C00, 0); send_beat(16'h4000, 0); send_beat(16'h4200, 0);
    pulse_reset();
    expect_next(16'h3C00, 1, 1'b0);
    send_beat(16'h3C00, 1);
    wait_drain();

    // Reset while a result is pending in OUT
    rdy_mode = 1;
    send_beat(16'h3C00, 0); send_beat(16'h4000, 1);
    @(negedge clk_i);
    check("pending result queued", exp_q.size(), 1);
    void'(exp_q.pop_front());
    pulse_reset();
    rdy_mode = 0;

    // Beat counter saturation
    for (int i = 0; i < CNT_MAX + 20; i++) send_beat(rand_fp16(), i == CNT_MAX + 19);
    wait_drain();

    // Randomized packets with idle gaps
    for (int k = 0; k < 60; k++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk_i);
        send_beat(rand_fp16(), i == len - 1);
      end
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
